pc_controller: RTL
==================

# pc_controller

Sequencing controller for the MIPS fetch stage. It drives the `program_counter` update port (`i_address`/`i_valid`) and the global pipeline enable. It chooses the next fetch address from PC+4, the branch target or the jump target, honours hazard stalls, and runs the debug unit's continuous and step-by-step modes. It also stops fetch on a HALT instruction and drains the pipeline before reporting halted.

## Interface
- `N_BITS`, 32, address/PC width
- `DRAIN_CYCLES`, 4, enabled cycles needed after HALT decode to empty the pipeline (≥1)
- `i_clk` in 1: single clock, rising edge
- `i_reset` in 1: synchronous, active-low; sampled at the rising edge of `i_clk`, 0 = reset
- `i_start_cont` in 1: debug unit, one-cycle pulse, start continuous mode
- `i_start_step` in 1: debug unit, one-cycle pulse, start step mode
- `i_step` in 1: debug unit, one-cycle pulse, advance one clock in step mode
- `i_stall` in 1: load-use hazard from ID, hold PC and IF/ID
- `i_branch_taken` in 1: branch resolved taken in ID
- `i_branch_addr` in N_BITS: branch target
- `i_jump` in 1: J/JAL/JR decoded in ID
- `i_jump_addr` in N_BITS: jump target
- `i_halt` in 1: HALT decoded in ID
- `i_pc` in N_BITS: current `program_counter` output
- `o_address` out N_BITS: next PC, to `program_counter.i_address`
- `o_valid` out 1: PC load enable, to `program_counter.i_valid`
- `o_pipe_en` out 1: enable for all pipeline registers
- `o_flush_if` out 1: clear IF/ID (redirect)
- `o_state` out 3: FSM state, for the debug unit
- `o_halted` out 1: program finished, pipeline drained
- `o_cycle_count` out 32: count of cycles with `o_pipe_en`=1

## Operation
- **States:** IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. A registered `drain_mode` bit records continuous (0) or step (1).
- **IDLE:** `o_pipe_en`=0.
  - `i_start_cont` → RUN.
  - Else `i_start_step` → STEP.
  - If both pulse together, RUN wins.
- **RUN:** `o_pipe_en`=1 every cycle.
- **STEP:** `o_pipe_en` = `i_step`. `i_start_*` are ignored outside IDLE.
- **HALT detection:** in RUN/STEP, the cycle with `o_pipe_en`=1, `i_halt`=1 and `i_stall`=0:
  - Go to DRAIN.
  - Load the drain counter with `DRAIN_CYCLES`-1.
  - Set `drain_mode`.
  - Force `o_valid`=0 in that cycle, so the PC is frozen on the HALT + 4 fetch.
- **DRAIN:** `o_pipe_en` = 1 (mode 0) or `i_step` (mode 1); `o_valid`=0. The counter decrements on enabled cycles. An enabled cycle with counter = 0 → HALTED.
- **HALTED:** `o_pipe_en`=0, `o_halted`=1. It stays there until reset.
- **Next-address priority:** `i_branch_taken` > `i_jump` > PC+4. PC+4 = `i_pc` + 4, modulo 2^N_BITS (0xFFFFFFFC → 0x00000000).
  - `o_address` is combinational and always shows the selected value.
- **Load enable:** `o_valid` = `o_pipe_en` & ~`i_stall` & ~halt_block.
- **Stall vs redirect:** stall beats redirect, because a stalled branch is not resolved. With `i_stall`=1, `o_flush_if`=0 and `o_valid`=0.
- **Flush:** `o_flush_if` = `o_pipe_en` & ~`i_stall` & (`i_branch_taken` | `i_jump`).
- **Cycle counter:** `o_cycle_count` increments on each cycle with `o_pipe_en`=1 and saturates at 0xFFFFFFFF.

## Timing
- **Reset values** (`i_reset`=0 at an edge): state IDLE, `drain_mode` 0, drain counter 0, `o_cycle_count` 0, `o_halted` 0, `o_pipe_en` 0, `o_valid` 0, `o_flush_if` 0, `o_state` 0. Reset in any state, including mid-DRAIN, takes effect at that edge.
- **Start latency:** a start pulse in cycle n gives the new state at the end of n; `o_pipe_en` goes high in cycle n+1.
- **Output timing:** `o_state`, `o_halted` and `o_cycle_count` are registered. `o_pipe_en`, `o_valid`, `o_flush_if` and `o_address` are combinational from state and inputs, with no added latency. The PC takes `o_address` at the same edge at which `o_valid` is high.
- **Drain length:** HALT decoded in cycle h (continuous mode) → DRAIN during h+1 … h+`DRAIN_CYCLES` → `o_halted`=1 in cycle h+`DRAIN_CYCLES`+1.
- **Step mode:** exactly one enabled cycle per `i_step` pulse. `i_step` in IDLE or HALTED is ignored.

## Structure
- **Shared package `mips_pkg`:** state encodings, `INSTR_BYTES`=4, default `DRAIN_CYCLES`.
- **Sub-module `pc_next_sel`:** purely combinational; holds the priority mux and the PC+4 adder.
- **Top level:** FSM, drain counter and cycle counter.

## Test plan
- **Continuous run:** reset, `i_pc`=0, `i_start_cont` pulse → `o_pipe_en`=1 next cycle, `o_valid`=1, `o_address`=0x4; `o_cycle_count`=3 after 3 enabled cycles.
- **Branch vs jump vs stall:** `i_branch_taken`=1, `i_branch_addr`=0x40 together with `i_jump`=1, `i_jump_addr`=0x80 → `o_address`=0x40, `o_flush_if`=1. Add `i_stall`=1 → `o_valid`=0, `o_flush_if`=0.
- **Halt drain:** `DRAIN_CYCLES`=4, `i_halt` in cycle h → `o_valid`=0 from h onward, `o_state`=3 during h+1…h+4, `o_halted`=1 at h+5, `o_pipe_en`=0.
- **Step mode:** `i_start_step`, then 3 `i_step` pulses 5 cycles apart → `o_pipe_en` high for exactly 3 single cycles, `o_cycle_count`=3. `i_halt` during a step → drain advances only on steps.
- **Wrap and reset:** `i_pc`=0xFFFFFFFC → `o_address`=0x0. `i_reset`=0 mid-DRAIN → next cycle `o_state`=0, `o_cycle_count`=0, `o_halted`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch-stage sequencing logic.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } pc_state_t;

    localparam int INSTR_BYTES          = 4;
    localparam int DEFAULT_DRAIN_CYCLES = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-fetch-address select: branch target over jump target over sequential PC.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic [N_BITS-1:0] pc,
    input  logic              branch_taken,
    input  logic [N_BITS-1:0] branch_addr,
    input  logic              jump,
    input  logic [N_BITS-1:0] jump_addr,
    output logic [N_BITS-1:0] next_addr
);

    localparam logic [N_BITS-1:0] PC_INC = N_BITS'(INSTR_BYTES);

    logic [N_BITS-1:0] pc_plus4;

    // Wraps modulo 2^N_BITS by construction.
    assign pc_plus4 = pc + PC_INC;

    always_comb begin
        next_addr = pc_plus4;
        if (branch_taken)
            next_addr = branch_addr;
        else if (jump)
            next_addr = jump_addr;
    end

endmodule

// File: rtl/pc_controller.sv
// Fetch sequencing FSM: run/step modes, hazard stall, redirect flush, HALT drain
// and an enabled-cycle counter.
module pc_controller
    import mips_pkg::*;
#(
    parameter int N_BITS       = 32,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start_cont,
    input  logic              i_start_step,
    input  logic              i_step,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [N_BITS-1:0] i_branch_addr,
    input  logic              i_jump,
    input  logic [N_BITS-1:0] i_jump_addr,
    input  logic              i_halt,
    input  logic [N_BITS-1:0] i_pc,
    output logic [N_BITS-1:0] o_address,
    output logic              o_valid,
    output logic              o_pipe_en,
    output logic              o_flush_if,
    output logic [2:0]        o_state,
    output logic              o_halted,
    output logic [31:0]       o_cycle_count
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    pc_state_t        state;
    logic             drain_mode;
    logic [CNT_W-1:0] drain_cnt;
    logic             halt_fire;
    logic             halt_block;

    pc_next_sel #(.N_BITS(N_BITS)) u_next_sel (
        .pc           (i_pc),
        .branch_taken (i_branch_taken),
        .branch_addr  (i_branch_addr),
        .jump         (i_jump),
        .jump_addr    (i_jump_addr),
        .next_addr    (o_address)
    );

    always_comb begin
        o_pipe_en = 1'b0;
        case (state)
            ST_RUN:   o_pipe_en = 1'b1;
            ST_STEP:  o_pipe_en = i_step;
            ST_DRAIN: o_pipe_en = drain_mode ? i_step : 1'b1;
            default:  o_pipe_en = 1'b0;
        endcase
    end

    // A stalled HALT is not yet decoded for real; it fires once the stall clears.
    assign halt_fire  = ((state == ST_RUN) || (state == ST_STEP)) &&
                        o_pipe_en && i_halt && !i_stall;
    assign halt_block = halt_fire || (state == ST_DRAIN);
    assign o_valid    = o_pipe_en && !i_stall && !halt_block;
    assign o_flush_if = o_pipe_en && !i_stall && (i_branch_taken || i_jump);
    assign o_state    = state;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            drain_mode    <= 1'b0;
            drain_cnt     <= '0;
            o_halted      <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            if (o_pipe_en && (o_cycle_count != 32'hFFFF_FFFF))
                o_cycle_count <= o_cycle_count + 32'd1;

            case (state)
                ST_IDLE: begin
                    if (i_start_cont)
                        state <= ST_RUN;
                    else if (i_start_step)
                        state <= ST_STEP;
                end
                ST_RUN, ST_STEP: begin
                    if (halt_fire) begin
                        state      <= ST_DRAIN;
                        drain_cnt  <= DRAIN_LOAD;
                        drain_mode <= (state == ST_STEP);
                    end
                end
                ST_DRAIN: begin
                    if (o_pipe_en) begin
                        if (drain_cnt == '0) begin
                            state    <= ST_HALTED;
                            o_halted <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule
